imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the decode-stage immediate extender: turns a 16-bit constant plus a destination
//  register into the shortest WISC sequence that materialises it. Fits signed 8 bits: a single LBI.
//  Otherwise: LBI (high byte) followed by SLBI (low byte).
//  Also reports the narrowest immediate format that reproduces the value. Used by the test-program
//  generator and the instruction-injection port in front of fetch.
// PARAMETERS
//  STAT_W  16  width of the optional encode-statistics counters
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset, synchronous, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept a request
//  req_value  in   16  constant to materialise
//  req_rd     in   3   destination register
//  instr_valid out 1   instr holds a valid instruction word
//  instr_ready in  1   consumer takes instr this cycle
//  instr      out  16  emitted instruction word
//  instr_last out  1   instr is the final word for the current request
//  fmt        out  3   narrowest format: 0 zero5, 1 zero8, 2 sign5, 4 sign8, 6 sign11
//  fmt_ok     out  1   1 if some format in fmt reproduces req_value; 0 means a full 16 bits is needed
// BEHAVIOUR
//  - Clock and reset: one clock, clk. rst_n is synchronous and active-low.
//  - Reset values: state IDLE, req_ready=1, instr_valid=0, instr=0, instr_last=0, fmt=0, fmt_ok=0.
//  - FSM states:
//    - IDLE:    req_ready=1. On req_valid, go to ONE if -128<=value<=127 (signed), else go to HI.
//    - ONE:     instr={5'b11000,rd,value[7:0]}, instr_last=1. On instr_ready, go to IDLE.
//    - HI:      instr={5'b11000,rd,value[15:8]}, instr_last=0. On instr_ready, go to LO.
//    - LO:      instr={5'b10010,rd,value[7:0]}, instr_last=1. On instr_ready, go to IDLE.
//  - req_ready=1 only in IDLE. There is no accept in the same cycle as the last-word handshake,
//    so a new request needs at least one IDLE cycle.
//  - Latency: request accepted at edge N; first word valid after edge N. The second word becomes
//    valid on the edge after the first word is accepted.
//  - Output stability: instr, instr_last, fmt and fmt_ok are registered. They stay stable while
//    instr_valid=1 and instr_ready=0.
//  - Latching: value and rd are captured at accept. Later req_* changes have no effect.
//  - fmt/fmt_ok latch at accept and hold until the next accept.
//  - fmt priority: zero5 (0..31), then sign5 (-16..-1), then zero8 (32..255), then sign8
//    (-128..-17), then sign11 (-1024..1023).
//  - No fit: fmt_ok=0 and fmt=3'd0.
//  - instr_ready while instr_valid=0 is ignored.
//  - Reset mid-sequence: rst_n=0 in HI, ONE or LO returns to IDLE on that edge.
//    Any pending word is dropped; no SLBI is emitted afterwards.
// CONFIGURATION
//  IMM_ENC_STATS_EN
//    Defined: adds outputs stat_short and stat_long, each [STAT_W-1:0].
//      - stat_short increments at the handshake of each ONE word.
//      - stat_long increments at the handshake of each LO word.
//      - Both saturate at all-ones and reset to 0.
//    Undefined: those ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package/include: LBI and SLBI opcodes (5'b11000, 5'b10010), fmt code constants,
//    FSM state encodings.
//  - Sub-module imm_fmt_class: combinational value -> {fmt, fmt_ok, fits_s8}.
//  - This module holds the FSM, the capture registers, the output registers and the optional stats.
// TESTING
//  1. value=0x0005, rd=3, instr_ready=1:
//     one word 0xC305, instr_last=1, fmt=0, fmt_ok=1; req_ready returns to 1 after it.
//  2. value=0x1234, rd=1:
//     0xC112 (last=0), then 0x9134 (last=1); fmt_ok=0.
//  3. value=0xFF80, rd=0: single word 0xC080, fmt=4. value=0x00FF, rd=2:
//     0xC200 then 0x92FF; fmt=1.
//  4. value=0x1234, instr_ready low for 3 cycles on each word: instr is held stable and req_ready=0
//     throughout. A new req_valid with a different value is ignored until IDLE.
//  5. rst_n=0 for one edge while 0xC112 is presented: next cycle instr_valid=0 and req_ready=1;
//     0x9134 is never emitted.
//  6. With IMM_ENC_STATS_EN: after cases 1–3, stat_short=2 and stat_long=2.
//     With STAT_W=2, 5 short encodes leave stat_short=3.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared constants for the immediate encoder: WISC opcodes, immediate format codes, FSM states.
// Also provides the instruction-word packing helper used by the encoder FSM.
package imm_encoder_pkg;

  localparam logic [4:0] OPC_LBI  = 5'b11000;
  localparam logic [4:0] OPC_SLBI = 5'b10010;

  localparam logic [2:0] FMT_ZERO5  = 3'd0;
  localparam logic [2:0] FMT_ZERO8  = 3'd1;
  localparam logic [2:0] FMT_SIGN5  = 3'd2;
  localparam logic [2:0] FMT_SIGN8  = 3'd4;
  localparam logic [2:0] FMT_SIGN11 = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  function automatic logic [15:0] mk_word(input logic [4:0] opc, input logic [2:0] rd,
                                          input logic [7:0] imm);
    return {opc, rd, imm};
  endfunction

endpackage

// File: rtl/imm_fmt_class.sv
// Combinational classifier: narrowest immediate format for a 16-bit value, plus signed-8 fit.
// Zero latency, no flow control.
module imm_fmt_class
  import imm_encoder_pkg::*;
(
  input  logic [15:0] i_value,
  output logic [2:0]  o_fmt,
  output logic        o_fmt_ok,
  output logic        o_fits_s8
);

  logic signed [15:0] w_sval;
  assign w_sval = i_value;

  // Order matters: the non-negative zero-extended formats win over the signed ones they overlap.
  always_comb begin
    o_fmt    = FMT_ZERO5;
    o_fmt_ok = 1'b0;
    if (w_sval >= 16'sd0 && w_sval <= 16'sd31) begin
      o_fmt    = FMT_ZERO5;
      o_fmt_ok = 1'b1;
    end else if (w_sval >= -16'sd16 && w_sval <= -16'sd1) begin
      o_fmt    = FMT_SIGN5;
      o_fmt_ok = 1'b1;
    end else if (w_sval >= 16'sd32 && w_sval <= 16'sd255) begin
      o_fmt    = FMT_ZERO8;
      o_fmt_ok = 1'b1;
    end else if (w_sval >= -16'sd128 && w_sval <= -16'sd17) begin
      o_fmt    = FMT_SIGN8;
      o_fmt_ok = 1'b1;
    end else if (w_sval >= -16'sd1024 && w_sval <= 16'sd1023) begin
      o_fmt    = FMT_SIGN11;
      o_fmt_ok = 1'b1;
    end
  end

  assign o_fits_s8 = (w_sval >= -16'sd128) && (w_sval <= 16'sd127);

endmodule

// File: rtl/imm_encoder.sv
// Turns a 16-bit constant into LBI or LBI+SLBI words; first word valid one edge after accept.
// Words hold under instr_ready=0; req_ready only in IDLE. IMM_ENC_STATS_EN adds encode counters.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_value,
  input  logic [2:0]        req_rd,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic              instr_last,
  output logic [2:0]        fmt,
`ifdef IMM_ENC_STATS_EN
  output logic              fmt_ok,
  output logic [STAT_W-1:0] stat_short,
  output logic [STAT_W-1:0] stat_long
`else
  output logic              fmt_ok
`endif
);

  typedef logic [STAT_W-1:0] stat_t;

  state_t     r_state;
  logic [2:0] r_rd;
  logic [7:0] r_lo;

  logic [2:0] w_fmt;
  logic       w_fmt_ok;
  logic       w_fits_s8;

  imm_fmt_class u_fmt_class (
    .i_value   (req_value),
    .o_fmt     (w_fmt),
    .o_fmt_ok  (w_fmt_ok),
    .o_fits_s8 (w_fits_s8)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rd        <= 3'd0;
      r_lo        <= 8'd0;
      req_ready   <= 1'b1;
      instr_valid <= 1'b0;
      instr       <= 16'd0;
      instr_last  <= 1'b0;
      fmt         <= 3'd0;
      fmt_ok      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_rd        <= req_rd;
            r_lo        <= req_value[7:0];
            fmt         <= w_fmt;
            fmt_ok      <= w_fmt_ok;
            req_ready   <= 1'b0;
            instr_valid <= 1'b1;
            if (w_fits_s8) begin
              r_state    <= ST_ONE;
              instr      <= mk_word(OPC_LBI, req_rd, req_value[7:0]);
              instr_last <= 1'b1;
            end else begin
              r_state    <= ST_HI;
              instr      <= mk_word(OPC_LBI, req_rd, req_value[15:8]);
              instr_last <= 1'b0;
            end
          end
        end
        ST_HI: begin
          if (instr_ready) begin
            r_state    <= ST_LO;
            instr      <= mk_word(OPC_SLBI, r_rd, r_lo);
            instr_last <= 1'b1;
          end
        end
        ST_ONE, ST_LO: begin
          // Last word leaves; one full IDLE cycle follows before the next accept.
          if (instr_ready) begin
            r_state     <= ST_IDLE;
            instr_valid <= 1'b0;
            instr_last  <= 1'b0;
            req_ready   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic w_hs_short;
  logic w_hs_long;
  assign w_hs_short = (r_state == ST_ONE) && instr_ready;
  assign w_hs_long  = (r_state == ST_LO) && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_short <= '0;
      stat_long  <= '0;
    end else begin
      if (w_hs_short && stat_short != '1) stat_short <= stat_short + stat_t'(1);
      if (w_hs_long && stat_long != '1)   stat_long  <= stat_long + stat_t'(1);
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table plus stall, latching and reset sequences.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_value;
  logic [2:0]  req_rd;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        instr_last;
  logic [2:0]  fmt;
  logic        fmt_ok;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef IMM_ENC_STATS_EN
  logic [15:0] stat_short, stat_long;
  logic [1:0]  s2_short, s2_long;
  logic        d2_req_ready, d2_instr_valid, d2_instr_last, d2_fmt_ok;
  logic [15:0] d2_instr;
  logic [2:0]  d2_fmt;

  imm_encoder #(.STAT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_rd(req_rd), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_last(instr_last),
    .fmt(fmt), .fmt_ok(fmt_ok), .stat_short(stat_short), .stat_long(stat_long)
  );

  imm_encoder #(.STAT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d2_req_ready),
    .req_value(req_value), .req_rd(req_rd), .instr_valid(d2_instr_valid),
    .instr_ready(instr_ready), .instr(d2_instr), .instr_last(d2_instr_last),
    .fmt(d2_fmt), .fmt_ok(d2_fmt_ok), .stat_short(s2_short), .stat_long(s2_long)
  );
`else
  imm_encoder #(.STAT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_rd(req_rd), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_last(instr_last),
    .fmt(fmt), .fmt_ok(fmt_ok)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic [2:0]  rd;
    int          nwords;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [2:0]  fmt;
    logic        fmt_ok;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{16'h0005, 3'd3, 1, 16'hC305, 16'h0000, 3'd0, 1'b1};
    vecs[1]  = '{16'h1234, 3'd1, 2, 16'hC112, 16'h9134, 3'd0, 1'b0};
    vecs[2]  = '{16'hFF80, 3'd0, 1, 16'hC080, 16'h0000, 3'd4, 1'b1};
    vecs[3]  = '{16'h00FF, 3'd2, 2, 16'hC200, 16'h92FF, 3'd1, 1'b1};
    vecs[4]  = '{16'hFFF0, 3'd7, 1, 16'hC7F0, 16'h0000, 3'd2, 1'b1};
    vecs[5]  = '{16'h0020, 3'd4, 1, 16'hC420, 16'h0000, 3'd1, 1'b1};
    vecs[6]  = '{16'hFFEF, 3'd5, 1, 16'hC5EF, 16'h0000, 3'd4, 1'b1};
    vecs[7]  = '{16'h03FF, 3'd6, 2, 16'hC603, 16'h96FF, 3'd6, 1'b1};
    vecs[8]  = '{16'hFC00, 3'd0, 2, 16'hC0FC, 16'h9000, 3'd6, 1'b1};
    vecs[9]  = '{16'h0400, 3'd1, 2, 16'hC104, 16'h9100, 3'd0, 1'b0};
    vecs[10] = '{16'h007F, 3'd2, 1, 16'hC27F, 16'h0000, 3'd1, 1'b1};
    vecs[11] = '{16'hFF7F, 3'd2, 2, 16'hC2FF, 16'h927F, 3'd6, 1'b1};
    vecs[12] = '{16'h001F, 3'd3, 1, 16'hC31F, 16'h0000, 3'd0, 1'b1};
    vecs[13] = '{16'h8000, 3'd7, 2, 16'hC780, 16'h9700, 3'd0, 1'b0};
    vecs[14] = '{16'hFFFF, 3'd4, 1, 16'hC4FF, 16'h0000, 3'd2, 1'b1};
    vecs[15] = '{16'h0080, 3'd4, 2, 16'hC400, 16'h9480, 3'd1, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_value = 16'd0; req_rd = 3'd0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_last", 32'(instr_last), 32'd0);
    chk("rst_fmt", 32'(fmt), 32'd0);
    chk("rst_fmt_ok", 32'(fmt_ok), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_value = vecs[i].value; req_rd = vecs[i].rd; instr_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_value = 16'h0000; req_rd = 3'd0;
      chk($sformatf("v%0d_w0", i), 32'(instr), 32'(vecs[i].w0));
      chk($sformatf("v%0d_w0_valid", i), 32'(instr_valid), 32'd1);
      chk($sformatf("v%0d_w0_last", i), 32'(instr_last), 32'(vecs[i].nwords == 1));
      chk($sformatf("v%0d_fmt", i), 32'(fmt), 32'(vecs[i].fmt));
      chk($sformatf("v%0d_fmt_ok", i), 32'(fmt_ok), 32'(vecs[i].fmt_ok));
      chk($sformatf("v%0d_busy_ready", i), 32'(req_ready), 32'd0);
      if (vecs[i].nwords == 2) begin
        @(negedge clk);
        chk($sformatf("v%0d_w1", i), 32'(instr), 32'(vecs[i].w1));
        chk($sformatf("v%0d_w1_last", i), 32'(instr_last), 32'd1);
        chk($sformatf("v%0d_w1_valid", i), 32'(instr_valid), 32'd1);
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_valid", i), 32'(instr_valid), 32'd0);
      chk($sformatf("v%0d_done_ready", i), 32'(req_ready), 32'd1);
      chk($sformatf("v%0d_fmt_hold", i), 32'(fmt), 32'(vecs[i].fmt));
`ifdef IMM_ENC_STATS_EN
      if (i == 3) begin
        chk("stat_short_after4", 32'(stat_short), 32'd2);
        chk("stat_long_after4", 32'(stat_long), 32'd2);
      end
`endif
    end

`ifdef IMM_ENC_STATS_EN
    chk("stat_short_table", 32'(stat_short), 32'd8);
    chk("stat_long_table", 32'(stat_long), 32'd8);
    chk("stat2_short_sat", 32'(s2_short), 32'd3);
    chk("stat2_long_sat", 32'(s2_long), 32'd3);
`endif

    // Stall each word for 3 cycles while a competing request is presented.
    @(negedge clk);
    req_valid = 1'b1; req_value = 16'h1234; req_rd = 3'd1; instr_ready = 1'b0;
    @(negedge clk);
    req_value = 16'h0055; req_rd = 3'd6;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_hi%0d_instr", c), 32'(instr), 32'hC112);
      chk($sformatf("stall_hi%0d_last", c), 32'(instr_last), 32'd0);
      chk($sformatf("stall_hi%0d_valid", c), 32'(instr_valid), 32'd1);
      chk($sformatf("stall_hi%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("stall_hi%0d_fmt_ok", c), 32'(fmt_ok), 32'd0);
      @(negedge clk);
    end
    chk("stall_hi_final", 32'(instr), 32'hC112);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_lo%0d_instr", c), 32'(instr), 32'h9134);
      chk($sformatf("stall_lo%0d_last", c), 32'(instr_last), 32'd1);
      chk($sformatf("stall_lo%0d_ready", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_valid", 32'(instr_valid), 32'd0);
    chk("stall_done_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
`ifdef IMM_ENC_STATS_EN
    chk("stat_long_stall", 32'(stat_long), 32'd9);
`endif

    // Reset while the LBI high word is presented: the SLBI must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_value = 16'h1234; req_rd = 3'd1; instr_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_seq_hi", 32'(instr), 32'hC112);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    chk("rst_seq_valid", 32'(instr_valid), 32'd0);
    chk("rst_seq_ready", 32'(req_ready), 32'd1);
    chk("rst_seq_fmt_ok", 32'(fmt_ok), 32'd0);
`ifdef IMM_ENC_STATS_EN
    chk("rst_seq_stat_long", 32'(stat_long), 32'd0);
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_idle%0d_valid", c), 32'(instr_valid), 32'd0);
      chk($sformatf("rst_seq_idle%0d_no_slbi", c), 32'(instr == 16'h9134), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
